load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with sub-word read-modify-write and fault checks
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state, state_nxt;

    logic        req_ready_q, resp_valid_q, resp_fault_q, mem_we_q;
    logic [31:0] resp_rdata_q, mem_addr_q, mem_wd_q;
    logic        req_ready_d, resp_valid_d, resp_fault_d, mem_we_d;
    logic [31:0] resp_rdata_d, mem_addr_d, mem_wd_d;

    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        fault;
    logic [2:0]  nbytes;
    logic [32:0] last_byte;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    return uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] w;
        w = word;
        if (size == 2'd0)
            w[{off, 3'b000} +: 8] = data[7:0];
        else
            w[{off[1], 4'b0000} +: 16] = data;
        return w;
    endfunction

    // Range check is done in 33 bits so an access near 2^32 cannot wrap back into range.
    always_comb begin
        case (bus.req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last_byte = {1'b0, bus.req_addr} + 33'(nbytes) - 33'd1;
        fault = (bus.req_size == 2'd3)
              | ((bus.req_size == 2'd1) & bus.req_addr[0])
              | ((bus.req_size == 2'd2) & (bus.req_addr[1:0] != 2'b00))
              | (last_byte > 33'(MEM_BYTES - 1));
    end

    assign accept = (state == S_IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fault)
                        state_nxt = S_RESP;
                    else if (!bus.req_we)
                        state_nxt = S_LOAD;
                    else if (bus.req_size == 2'd2)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_RMW_READ;
                end
            end
            S_LOAD:     state_nxt = S_RESP;
            S_RMW_READ: state_nxt = S_WRITE;
            S_WRITE:    state_nxt = S_RESP;
            S_RESP:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered, so they line up with it.
    always_comb begin
        req_ready_d  = (state_nxt == S_IDLE);
        resp_valid_d = (state_nxt == S_RESP);
        mem_we_d     = (state_nxt == S_WRITE);
        resp_fault_d = accept && fault;
        resp_rdata_d = 32'h0;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        if (state == S_LOAD)
            resp_rdata_d = load_extend(bus.mem_rd, size_q, off_q, uns_q);
        if (accept && !fault) begin
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we && (bus.req_size == 2'd2))
                mem_wd_d = bus.req_wdata;
        end
        if (state == S_RMW_READ)
            mem_wd_d = store_merge(bus.mem_rd, wdata_q, size_q, off_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wd_q     <= 32'h0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    // Request fields are held here so the pipeline may drop or change them after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 16'h0;
        end else if (accept) begin
            size_q  <= bus.req_size;
            off_q   <= bus.req_addr[1:0];
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata[15:0];
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];
    assign bus.mem_rd = mem[bus.mem_addr[9:2]];
    always @(negedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;

    int we_cycles = 0;
    int resp_cycles = 0;
    always @(negedge clk) begin
        if (bus.mem_we) we_cycles++;
        if (bus.resp_valid) resp_cycles++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE, returns at the negedge of the IDLE cycle after the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic flt, output int lat,
                          output int wes, output logic busy_ready);
        int we0;
        we0 = we_cycles;
        lat = 99;
        rdata = 32'hDEADDEAD;
        flt = 1'b0;
        busy_ready = 1'b0;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we = ~we;
        bus.req_size = ~size;
        bus.req_unsigned = ~uns;
        bus.req_addr = ~addr;
        bus.req_wdata = ~wdata;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = c;
                rdata = bus.resp_rdata;
                flt = bus.resp_fault;
                break;
            end
            busy_ready |= bus.req_ready;
        end
        @(negedge clk);
        wes = we_cycles - we0;
    endtask

    task automatic run(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault,
                       input int exp_lat, input int exp_we);
        logic [31:0] rd;
        logic        f;
        int          lat;
        int          wes;
        logic        br;
        do_req(we, size, uns, addr, wdata, rd, f, lat, wes, br);
        check({name, "/rdata"}, rd, exp_rdata);
        check({name, "/fault"}, 32'(f), 32'(exp_fault));
        check({name, "/latency"}, lat, exp_lat);
        check({name, "/we_cycles"}, wes, exp_we);
        check({name, "/ready_busy"}, 32'(br), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c1, c2, rdy_cnt, rdy_cycle, nr, resp0;
        logic [31:0] rd;

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]   = 32'h8899AABB;
        mem[8]   = 32'h11223344;
        mem[255] = 32'hCAFEF00D;

        repeat (2) @(negedge clk);
        check("rst/req_ready", 32'(bus.req_ready), 32'h1);
        check("rst/resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst/resp_fault", 32'(bus.resp_fault), 32'h0);
        check("rst/resp_rdata", bus.resp_rdata, 32'h0);
        check("rst/mem_we", 32'(bus.mem_we), 32'h0);
        check("rst/mem_addr", bus.mem_addr, 32'h0);
        check("rst/mem_wd", bus.mem_wd, 32'h0);
        rst_n = 1'b1;

        run("lb_s_11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        run("lbu_11",   1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        run("lh_s_12",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        run("lhu_12",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
        run("lh_s_10",  1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
        run("lb_s_13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
        run("lbu_10",   1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h000000BB, 1'b0, 2, 0);
        run("lw_10",    1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);

        run("sb_12", 1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF55, 32'h0, 1'b0, 3, 1);
        check("sb_12/mem", mem[4], 32'h8855AABB);
        run("sh_10", 1'b1, 2'd1, 1'b0, 32'h10, 32'hABCD1234, 32'h0, 1'b0, 3, 1);
        check("sh_10/mem", mem[4], 32'h88551234);
        run("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000EE, 32'h0, 1'b0, 3, 1);
        check("sb_13/mem", mem[4], 32'hEE551234);
        run("lw_after_st", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hEE551234, 1'b0, 2, 0);

        run("flt_lw_13",   1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_lh_11",   1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_size3",   1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_lw_top2", 1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 2), 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_lb_oor",  1'b0, 2'd0, 1'b0, 32'(MEM_BYTES), 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_lh_wrap", 1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0);
        run("flt_sw_22",   1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
        check("flt_sw_22/mem", mem[8], 32'h11223344);
        run("flt_sh_oor",  1'b1, 2'd1, 1'b0, 32'(MEM_BYTES), 32'hFFFF, 32'h0, 1'b1, 1, 0);

        run("lw_top",   1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);
        run("lb_s_top", 1'b0, 2'd0, 1'b0, 32'(MEM_BYTES - 1), 32'h0, 32'hFFFFFFCA, 1'b0, 2, 0);
        run("lhu_top",  1'b0, 2'd1, 1'b1, 32'(MEM_BYTES - 2), 32'h0, 32'h0000CAFE, 1'b0, 2, 0);

        // Back-to-back: req_valid stays high from the store through the load.
        c1 = 99; c2 = 99; rdy_cnt = 0; rdy_cycle = 0; nr = 0; rd = 32'h0;
        bus.req_we = 1'b1;
        bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h30;
        bus.req_wdata = 32'h5A5AA5A5;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                nr++;
                if (nr == 1) c1 = c;
                else begin
                    c2 = c;
                    rd = bus.resp_rdata;
                    break;
                end
            end
            if (bus.req_ready) begin
                rdy_cnt++;
                rdy_cycle = c;
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b/store_latency", c1, 2);
        check("b2b/idle_cycle", rdy_cycle, 3);
        check("b2b/ready_count", rdy_cnt, 1);
        check("b2b/load_latency", c2, 5);
        check("b2b/load_data", rd, 32'h5A5AA5A5);

        // Reset pulsed during the WRITE cycle of a word store.
        resp0 = resp_cycles;
        bus.req_we = 1'b1;
        bus.req_size = 2'd2;
        bus.req_addr = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rstw/we_in_write", 32'(bus.mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw/we_async_low", 32'(bus.mem_we), 32'h0);
        check("rstw/ready_in_rst", 32'(bus.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstw/no_resp", resp_cycles - resp0, 0);
        check("rstw/mem_kept", mem[8], 32'h11223344);
        check("rstw/ready_after", 32'(bus.req_ready), 32'h1);

        run("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
